board_mem_arbiter: RTL and testbench



---
 rtl/board_pkg.sv | 46 ++++
 rtl/board_mem_core.sv | 42 ++++
 rtl/board_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_board_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
//   Shared definitions for the board store and its arbiter.
//   - BOARD_ADDR_W / BOARD_CELLS : board geometry (64 cells, 6-bit address)
//   - cell_t                     : 2-bit cell encoding (value 3 is reserved)
//   - client_t                   : requester identities on the store port
//   - rr_grant()                 : two-client round-robin grant decision
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int BOARD_ADDR_W = 6;
    localparam int BOARD_CELLS  = 1 << BOARD_ADDR_W;
    localparam int CELL_W       = 2;

    typedef enum logic [CELL_W-1:0] {
        CELL_EMPTY = 2'd0,
        CELL_BLACK = 2'd1,
        CELL_WHITE = 2'd2,
        CELL_RSVD  = 2'd3
    } cell_t;

    // Client 0 is the board-clear engine, client 1 is game logic.
    typedef enum logic {
        CLI_CLEAR = 1'b0,
        CLI_GAME  = 1'b1
    } client_t;

    // Grant vector layout: bit 0 = clear engine, bit 1 = game logic.
    // With both eligible, the client that did not win the last grant wins.
    function automatic logic [1:0] rr_grant(input logic    elig_clear,
                                            input logic    elig_game,
                                            input client_t last_grant);
        logic [1:0] gnt;
        gnt = 2'b00;
        if (elig_clear && elig_game) begin
            if (last_grant == CLI_CLEAR) gnt = 2'b10;
            else                         gnt = 2'b01;
        end else if (elig_clear) begin
            gnt = 2'b01;
        end else if (elig_game) begin
            gnt = 2'b10;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/board_mem_core.sv
// -----------------------------------------------------------------------------
// board_mem_core
//   Single-port register array holding the board cells. One access per cycle:
//   a write when we=1, and rdata is registered from the addressed cell at
//   every edge (old contents on a write cycle).
//
//   Ports:
//     clk    in   clock
//     we     in   write enable for this cycle's access
//     addr   in   [ADDR_W-1:0] cell address
//     wdata  in   [DATA_W-1:0] write data
//     rdata  out  [DATA_W-1:0] registered read data (no reset)
// -----------------------------------------------------------------------------
module board_mem_core
    import board_pkg::*;
#(
    parameter int ADDR_W = BOARD_ADDR_W,
    parameter int DATA_W = CELL_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; clearing it is a sequence of
    // ordinary writes by the clear engine, which keeps this a plain RAM.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// board_mem_arbiter
//   Owns the 64 x 2-bit board store and arbitrates two en/valid requesters
//   onto its single port, round-robin on conflict.
//
//   Ports:
//     clk       in   clock
//     rst_n     in   synchronous active-low reset
//     c0_en     in   clear engine write request
//     c0_valid  out  clear engine completion pulse
//     c0_addr   in   [ADDR_W-1:0] clear engine cell address
//     c0_data   in   [DATA_W-1:0] clear engine write data
//     c1_en     in   game logic request
//     c1_we     in   game logic direction: 1 = write, 0 = read
//     c1_addr   in   [ADDR_W-1:0] game logic cell address
//     c1_wdata  in   [DATA_W-1:0] game logic write data
//     c1_rdata  out  [DATA_W-1:0] game logic read data (held until next read)
//     c1_valid  out  game logic completion pulse
// -----------------------------------------------------------------------------
module board_mem_arbiter
    import board_pkg::*;
#(
    parameter int ADDR_W = BOARD_ADDR_W,
    parameter int DATA_W = CELL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_en,
    output logic              c0_valid,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_data,
    input  logic              c1_en,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_valid
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              c0_valid_q;
    logic              c1_valid_q;
    client_t           last_grant_q;
    logic              rd_done_q;     // a client 1 read completes this cycle
    logic [DATA_W-1:0] rdata_hold_q;  // last completed read, held between reads

    // -------------------------------------------------------------------------
    // Eligibility and grant
    // -------------------------------------------------------------------------
    logic       elig_clear;
    logic       elig_game;
    logic [1:0] grant;
    logic       gnt_clear;
    logic       gnt_game;

    // A client still holds en during its own valid cycle; masking with valid
    // stops that cycle from being taken as a fresh request.
    assign elig_clear = c0_en & ~c0_valid_q;
    assign elig_game  = c1_en & ~c1_valid_q;
    assign grant      = rr_grant(elig_clear, elig_game, last_grant_q);
    assign gnt_clear  = grant[0];
    assign gnt_game   = grant[1];

    // -------------------------------------------------------------------------
    // Store port mux
    // -------------------------------------------------------------------------
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = c0_addr;
        mem_wdata = c0_data;
        if (gnt_game) begin
            mem_we    = c1_we;
            mem_addr  = c1_addr;
            mem_wdata = c1_wdata;
        end else if (gnt_clear) begin
            mem_we    = 1'b1;
        end
        // A write landing on an edge where reset is sampled is dropped.
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    board_mem_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // -------------------------------------------------------------------------
    // Completion, round-robin pointer and read-data hold
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c0_valid_q   <= 1'b0;
            c1_valid_q   <= 1'b0;
            last_grant_q <= CLI_GAME;       // clear engine wins the first conflict
            rd_done_q    <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            c0_valid_q <= gnt_clear;
            c1_valid_q <= gnt_game;
            rd_done_q  <= gnt_game & ~c1_we;
            if (gnt_clear) begin
                last_grant_q <= CLI_CLEAR;
            end else if (gnt_game) begin
                last_grant_q <= CLI_GAME;
            end
            // The core's rdata is only meaningful in the completion cycle;
            // capture it then so later accesses by either client cannot
            // disturb what client 1 sees.
            if (rd_done_q) begin
                rdata_hold_q <= mem_rdata;
            end
        end
    end

    assign c0_valid = c0_valid_q;
    assign c1_valid = c1_valid_q;
    assign c1_rdata = rd_done_q ? mem_rdata : rdata_hold_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_board_mem_arbiter
//   Self-checking bench for board_mem_arbiter: a table of per-cycle vectors,
//   hand-written multi-cycle sequences (clear sweep, reset mid-access,
//   abandoned request) and a randomized phase against a reference model.
// -----------------------------------------------------------------------------
module tb_board_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       c0_en;
    logic       c0_valid;
    logic [5:0] c0_addr;
    logic [1:0] c0_data;
    logic       c1_en;
    logic       c1_we;
    logic [5:0] c1_addr;
    logic [1:0] c1_wdata;
    logic [1:0] c1_rdata;
    logic       c1_valid;

    int n_vec;
    int n_fail;

    board_mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c0_en    (c0_en),
        .c0_valid (c0_valid),
        .c0_addr  (c0_addr),
        .c0_data  (c0_data),
        .c1_en    (c1_en),
        .c1_we    (c1_we),
        .c1_addr  (c1_addr),
        .c1_wdata (c1_wdata),
        .c1_rdata (c1_rdata),
        .c1_valid (c1_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0_en = 1'b0; c0_addr = '0; c0_data = '0;
        c1_en = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
    endtask

    // One complete client 1 transaction, bounded; returns the read data seen
    // in the valid cycle and leaves one idle cycle after dropping en.
    task automatic c1_access(input logic we, input logic [5:0] a, input logic [1:0] d,
                             output logic [1:0] rd);
        logic seen;
        seen = 1'b0;
        c1_en = 1'b1; c1_we = we; c1_addr = a; c1_wdata = d;
        for (int n = 0; n < 8 && !seen; n++) begin
            tick();
            if (c1_valid) seen = 1'b1;
        end
        rd = c1_rdata;
        check("c1_handshake", {31'd0, seen}, 32'd1);
        c1_en = 1'b0;
        tick();
    endtask

    // ---------------------------------------------------------------------
    // Table-driven vectors: inputs for cycle t, expected outputs in t+1
    // ---------------------------------------------------------------------
    typedef struct {
        logic       c0_en;
        logic [5:0] c0_addr;
        logic [1:0] c0_data;
        logic       c1_en;
        logic       c1_we;
        logic [5:0] c1_addr;
        logic [1:0] c1_wdata;
        logic       e_v0;
        logic       e_v1;
        logic [1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(logic a_en, int a_addr, int a_d,
                                logic b_en, logic b_we, int b_addr, int b_d,
                                logic ev0, logic ev1, int erd);
        vec_t v;
        v.c0_en = a_en; v.c0_addr = 6'(a_addr); v.c0_data = 2'(a_d);
        v.c1_en = b_en; v.c1_we = b_we; v.c1_addr = 6'(b_addr); v.c1_wdata = 2'(b_d);
        v.e_v0 = ev0; v.e_v1 = ev1; v.e_rd = 2'(erd);
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Reference model: store contents, round-robin winner, completion flags
    // ---------------------------------------------------------------------
    int m_store [64];
    int m_last;          // 0 = clear engine won last, 1 = game logic won last
    bit m_v0, m_v1;      // valid flags for the upcoming cycle
    int m_rd;

    task automatic model_step();
        bit e0, e1;
        int winner;
        e0 = c0_en && !m_v0;
        e1 = c1_en && !m_v1;
        winner = -1;
        if (e0 && e1)  winner = 1 - m_last;
        else if (e0)   winner = 0;
        else if (e1)   winner = 1;
        m_v0 = (winner == 0);
        m_v1 = (winner == 1);
        if (winner >= 0) m_last = winner;
        if (winner == 0) m_store[c0_addr] = int'(c0_data);
        if (winner == 1) begin
            if (c1_we) m_store[c1_addr] = int'(c1_wdata);
            else       m_rd = m_store[c1_addr];
        end
    endtask

    vec_t tbl [26];
    logic [1:0] rd;

    initial begin
        n_vec = 0;
        n_fail = 0;
        idle_inputs();

        // ------------------------------ reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_c0_valid", {31'd0, c0_valid}, 32'd0);
        check("rst_c1_valid", {31'd0, c1_valid}, 32'd0);
        check("rst_c1_rdata", {30'd0, c1_rdata}, 32'd0);
        rst_n = 1'b1;

        // ------------------------------ table
        //               c0: en addr d   c1: en we addr d    exp: v0 v1 rd
        tbl[0]  = mk(1, 5, 0,      1, 1, 63, 2,      1, 0, 0); // conflict: c0 first
        tbl[1]  = mk(0, 0, 0,      1, 1, 63, 2,      0, 1, 0); // c1 served next cycle
        tbl[2]  = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 0);
        tbl[3]  = mk(0, 0, 0,      1, 0, 63, 0,      0, 1, 2); // read 63
        tbl[4]  = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 2); // held
        tbl[5]  = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 2);
        tbl[6]  = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 2);
        tbl[7]  = mk(0, 0, 0,      1, 0, 5, 0,       0, 1, 0); // read cleared cell 5
        tbl[8]  = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 0);
        tbl[9]  = mk(1, 10, 3,     1, 1, 10, 1,      1, 0, 0); // same-address conflict
        tbl[10] = mk(0, 0, 0,      1, 1, 10, 1,      0, 1, 0);
        tbl[11] = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 0);
        tbl[12] = mk(1, 11, 1,     0, 0, 0, 0,       1, 0, 0); // c0 alone
        tbl[13] = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 0);
        tbl[14] = mk(1, 12, 2,     1, 1, 12, 3,      0, 1, 0); // conflict: c1 first now
        tbl[15] = mk(1, 12, 2,     0, 0, 0, 0,       1, 0, 0);
        tbl[16] = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 0);
        tbl[17] = mk(0, 0, 0,      1, 0, 12, 0,      0, 1, 2); // c0 wrote last
        tbl[18] = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 2);
        tbl[19] = mk(0, 0, 0,      1, 0, 10, 0,      0, 1, 1); // c1 wrote last
        tbl[20] = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 1);
        tbl[21] = mk(0, 0, 0,      1, 1, 20, 3,      0, 1, 1); // reserved value, write keeps rdata
        tbl[22] = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 1);
        tbl[23] = mk(1, 20, 1,     0, 0, 0, 0,       1, 0, 1);
        tbl[24] = mk(0, 0, 0,      1, 0, 20, 0,      0, 1, 1); // read right after write
        tbl[25] = mk(0, 0, 0,      0, 0, 0, 0,       0, 0, 1);

        for (int i = 0; i < 26; i++) begin
            c0_en = tbl[i].c0_en; c0_addr = tbl[i].c0_addr; c0_data = tbl[i].c0_data;
            c1_en = tbl[i].c1_en; c1_we = tbl[i].c1_we;
            c1_addr = tbl[i].c1_addr; c1_wdata = tbl[i].c1_wdata;
            tick();
            check($sformatf("tbl%0d_c0_valid", i), {31'd0, c0_valid}, {31'd0, tbl[i].e_v0});
            check($sformatf("tbl%0d_c1_valid", i), {31'd0, c1_valid}, {31'd0, tbl[i].e_v1});
            check($sformatf("tbl%0d_c1_rdata", i), {30'd0, c1_rdata}, {30'd0, tbl[i].e_rd});
        end
        idle_inputs();
        tick();

        // ------------------------------ reset during a read
        c1_access(1'b1, 6'd5, 2'd2, rd);
        c1_access(1'b0, 6'd5, 2'd0, rd);
        check("pre_rst_read", {30'd0, rd}, 32'd2);
        c1_en = 1'b1; c1_we = 1'b0; c1_addr = 6'd5;
        rst_n = 1'b0;                       // sampled at the edge ending the grant cycle
        tick();
        check("rst_rd_valid", {31'd0, c1_valid}, 32'd0);
        check("rst_rd_data", {30'd0, c1_rdata}, 32'd0);
        c1_en = 1'b0; rst_n = 1'b1;
        tick();
        check("rst_rd_valid_after", {31'd0, c1_valid}, 32'd0);
        check("rst_rd_data_after", {30'd0, c1_rdata}, 32'd0);
        c1_access(1'b0, 6'd5, 2'd0, rd);
        check("post_rst_read", {30'd0, rd}, 32'd2);

        // ------------------------------ write dropped by reset
        c1_access(1'b1, 6'd6, 2'd1, rd);
        c0_en = 1'b1; c0_addr = 6'd6; c0_data = 2'd3;
        rst_n = 1'b0;
        tick();
        check("rst_wr_valid", {31'd0, c0_valid}, 32'd0);
        c0_en = 1'b0; rst_n = 1'b1;
        tick();
        c1_access(1'b0, 6'd6, 2'd0, rd);
        check("rst_wr_not_done", {30'd0, rd}, 32'd1);

        // ------------------------------ abandoned request
        rst_n = 1'b0; tick(); rst_n = 1'b1;  // clear engine wins next conflict
        c1_access(1'b1, 6'd7, 2'd2, rd);     // leaves last grant with game logic
        c0_en = 1'b1; c0_addr = 6'd8; c0_data = 2'd0;
        c1_en = 1'b1; c1_we = 1'b1; c1_addr = 6'd7; c1_wdata = 2'd3;
        tick();
        check("abandon_c0_won", {31'd0, c0_valid}, 32'd1);
        check("abandon_c1_wait", {31'd0, c1_valid}, 32'd0);
        c0_en = 1'b0; c1_en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("abandon_no_c1_valid", {31'd0, c1_valid}, 32'd0);
        end
        c1_access(1'b0, 6'd7, 2'd0, rd);
        check("abandon_no_write", {30'd0, rd}, 32'd2);

        // ------------------------------ full clear sweep
        for (int a = 0; a < 64; a++) c1_access(1'b1, 6'(a), 2'd1, rd);
        begin
            int  pulses;
            logic prev;
            logic done;
            pulses = 0; prev = 1'b0; done = 1'b0;
            c0_addr = 6'd0; c0_data = 2'd0; c0_en = 1'b1;   // en held continuously
            for (int n = 0; n < 200 && !done; n++) begin
                tick();
                if (c0_valid) begin
                    pulses++;
                    check("sweep_no_b2b", {31'd0, prev}, 32'd0);
                    if (c0_addr == 6'd63) begin
                        c0_en = 1'b0;
                        done = 1'b1;
                    end else begin
                        c0_addr = c0_addr + 6'd1;
                    end
                end
                prev = c0_valid;
            end
            tick();
            check("sweep_last_pulse", {31'd0, c0_valid}, 32'd0);
            check("sweep_pulses", pulses, 32'd64);
        end
        for (int a = 0; a < 64; a++) begin
            c1_access(1'b0, 6'(a), 2'd0, rd);
            check($sformatf("sweep_cell%0d", a), {30'd0, rd}, 32'd0);
        end

        // ------------------------------ randomized against the model
        idle_inputs();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        for (int a = 0; a < 64; a++) m_store[a] = 0;
        m_last = 1; m_v0 = 1'b0; m_v1 = 1'b0; m_rd = 0;
        begin
            bit p0, p1;
            p0 = 1'b0; p1 = 1'b0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (m_v0) begin
                    c0_en = 1'b0; p0 = 1'b0;
                end else if (p0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        c0_en = 1'b0; p0 = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        c0_addr = 6'($urandom_range(0, 7));
                        c0_data = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 1) == 1) begin
                    p0 = 1'b1; c0_en = 1'b1;
                    c0_addr = 6'($urandom_range(0, 7));
                    c0_data = 2'($urandom_range(0, 3));
                end

                if (m_v1) begin
                    c1_en = 1'b0; p1 = 1'b0;
                end else if (p1) begin
                    if ($urandom_range(0, 7) == 0) begin
                        c1_en = 1'b0; p1 = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        c1_addr  = 6'($urandom_range(0, 7));
                        c1_wdata = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 1) == 1) begin
                    p1 = 1'b1; c1_en = 1'b1;
                    c1_we    = 1'($urandom_range(0, 1));
                    c1_addr  = 6'($urandom_range(0, 7));
                    c1_wdata = 2'($urandom_range(0, 3));
                end

                model_step();
                tick();
                check("rnd_c0_valid", {31'd0, c0_valid}, {31'd0, m_v0});
                check("rnd_c1_valid", {31'd0, c1_valid}, {31'd0, m_v1});
                check("rnd_c1_rdata", {30'd0, c1_rdata}, m_rd);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
